// File: rtl/awmc_pkg.sv
// rtl/awmc_pkg.sv - shared stage codes and panel state type for the washing machine controller
package awmc_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b111;
  localparam logic [2:0] ST_FILL  = 3'b000;
  localparam logic [2:0] ST_WASH  = 3'b001;
  localparam logic [2:0] ST_RINSE = 3'b010;
  localparam logic [2:0] ST_SPIN  = 3'b011;
  localparam logic [2:0] ST_STOP  = 3'b100;

  typedef enum logic [2:0] {
    P_IDLE,
    P_RUN,
    P_HOLD,
    P_DONE,
    P_RESTART
  } panel_state_t;

  function automatic logic is_busy(panel_state_t s);
    return (s == P_RUN) || (s == P_HOLD) || (s == P_RESTART);
  endfunction

endpackage

// File: rtl/awmc_debounce.sv
// rtl/awmc_debounce.sv - 2-flop synchronizer plus stability counter for one raw panel input
module awmc_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_settle;

  // The level flips only on the sample after DEBOUNCE_CYCLES differing samples.
  assign w_settle = (r_sync2 != r_level) && (r_cnt == C_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= w_settle && r_sync2;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_settle) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/awmc_panel.sv
// rtl/awmc_panel.sv - front-panel command FSM, stage display and completion buzzer
module awmc_panel
  import awmc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BUZZ_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       lid_sw,
  input  logic [2:0] stage,
  input  logic       done,
  output logic       start,
  output logic       pause,
  output logic       lid,
  output logic       ctrl_rst,
  output logic       buzzer,
  output logic [2:0] disp_stage,
  output logic       busy
);

  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYCLES);

  logic w_start_rise;
  logic w_pause_rise;
  logic w_lid;
  logic w_unused_start_lvl;
  logic w_unused_pause_lvl;
  logic w_unused_lid_rise;

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_start),
    .o_level (w_unused_start_lvl),
    .o_rise  (w_start_rise)
  );

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_pause),
    .o_level (w_unused_pause_lvl),
    .o_rise  (w_pause_rise)
  );

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lid (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (lid_sw),
    .o_level (w_lid),
    .o_rise  (w_unused_lid_rise)
  );

  panel_state_t  r_state;
  panel_state_t  w_state_n;
  logic          r_start;
  logic          r_pause;
  logic          r_ctrl_rst;
  logic          r_buzzer;
  logic          r_busy;
  logic [2:0]    r_disp;
  logic [BW-1:0] r_buzz_cnt;
  logic          w_start_n;
  logic          w_pause_n;
  logic          w_ctrl_rst_n;
  logic [BW-1:0] w_buzz_n;

  always_comb begin
    w_state_n    = r_state;
    w_start_n    = 1'b0;
    w_ctrl_rst_n = 1'b0;
    w_pause_n    = r_pause;
    w_buzz_n     = (r_buzz_cnt != '0) ? r_buzz_cnt - 1'b1 : '0;
    case (r_state)
      P_IDLE: begin
        w_pause_n = 1'b0;
        if (w_start_rise && !w_lid) begin
          w_start_n = 1'b1;
          w_state_n = P_RUN;
        end
      end
      P_RUN: begin
        if (done) begin
          w_pause_n = 1'b0;
          w_state_n = P_DONE;
        end else if (w_pause_rise) begin
          w_pause_n = 1'b1;
          w_state_n = P_HOLD;
        end
      end
      P_HOLD: begin
        // Resume is signalled by pause dropping; no second start pulse.
        if (done) begin
          w_pause_n = 1'b0;
          w_state_n = P_DONE;
        end else if (w_start_rise) begin
          w_pause_n = 1'b0;
          w_state_n = P_RUN;
        end
      end
      P_DONE: begin
        if (!r_buzzer && w_start_rise && !w_lid) begin
          w_ctrl_rst_n = 1'b1;
          w_state_n    = P_RESTART;
        end
      end
      P_RESTART: begin
        w_start_n = 1'b1;
        w_state_n = P_RUN;
      end
      default: begin
        w_state_n = P_IDLE;
      end
    endcase
    if ((w_state_n == P_DONE) && (r_state != P_DONE)) begin
      w_buzz_n = BUZZ_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= P_IDLE;
      r_start    <= 1'b0;
      r_pause    <= 1'b0;
      r_ctrl_rst <= 1'b1;
      r_buzzer   <= 1'b0;
      r_busy     <= 1'b0;
      r_disp     <= ST_IDLE;
      r_buzz_cnt <= '0;
    end else begin
      r_state    <= w_state_n;
      r_start    <= w_start_n;
      r_pause    <= w_pause_n;
      r_ctrl_rst <= w_ctrl_rst_n;
      r_buzz_cnt <= w_buzz_n;
      r_buzzer   <= (w_buzz_n != '0);
      r_busy     <= is_busy(w_state_n);
      if (stage != ST_IDLE) begin
        r_disp <= stage;
      end
    end
  end

  assign start      = r_start;
  assign pause      = r_pause;
  assign lid        = w_lid;
  assign ctrl_rst   = r_ctrl_rst;
  assign buzzer     = r_buzzer;
  assign disp_stage = r_disp;
  assign busy       = r_busy;

endmodule
